// File: rtl/seq_detect_pkg.sv
// Shared types and width helper for the serial pattern detector with LED hold.
package seq_detect_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } led_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_detect_led_hold_timer.sv
// Loadable down-counter for the LED hold time; stops at zero and flags it.
module hold_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_detect_led.sv
// Serial pattern detector: history/fill tracking, LED hold FSM and a saturating
// match counter. All outputs are registered.
module seq_detect_led
    import seq_detect_pkg::*;
#(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
    parameter int                     HOLD_CYCLES = 8,
    parameter bit                     OVERLAP     = 1'b1,
    parameter bit                     RETRIGGER   = 1'b1,
    parameter int                     CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w,
    input  logic             w_valid,
    input  logic             clear,
    output logic             led_out,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count
);

    localparam int TW = clog2_min1(HOLD_CYCLES);
    localparam int FW = clog2_min1(PATTERN_LEN + 1);
    localparam logic [TW-1:0] HOLD_RELOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [FW-1:0] FILL_MAX    = FW'(PATTERN_LEN);
    localparam logic [FW-1:0] FILL_THR    = FW'(PATTERN_LEN - 1);

    // The oldest history bit is never compared against the incoming bit's
    // window, so only the newest PATTERN_LEN-1 bits are stored.
    logic [PATTERN_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]          fill_q, fill_d;
    led_state_t             state_q, state_d;
    logic                   pulse_q, pulse_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [PATTERN_LEN-1:0] window;
    logic                   match;
    logic                   timer_load;
    logic                   timer_dec;
    logic                   timer_zero;
    logic [TW-1:0]          timer_val;

    assign window = {hist_q, w};
    assign match  = w_valid && (fill_q >= FILL_THR) && (window == PATTERN);

    always_comb begin
        hist_d     = hist_q;
        fill_d     = fill_q;
        state_d    = state_q;
        pulse_d    = 1'b0;
        count_d    = count_q;
        timer_load = 1'b0;
        timer_val  = HOLD_RELOAD;
        timer_dec  = 1'b0;

        if (clear) begin
            hist_d     = '0;
            fill_d     = '0;
            state_d    = S_IDLE;
            timer_load = 1'b1;
            timer_val  = '0;
        end else begin
            if (w_valid) begin
                if (match && !OVERLAP) begin
                    hist_d = '0;
                    fill_d = '0;
                end else begin
                    hist_d = window[PATTERN_LEN-2:0];
                    if (fill_q != FILL_MAX) begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end

            if (match) begin
                pulse_d = 1'b1;
                if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (match) begin
                        state_d    = S_HOLD;
                        timer_load = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (match && RETRIGGER) begin
                        timer_load = 1'b1;
                    end else if (timer_zero) begin
                        state_d = S_IDLE;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= S_IDLE;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    hold_timer #(
        .W(TW)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    assign led_out     = (state_q == S_HOLD);
    assign match_pulse = pulse_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_led.sv
// Scoreboard bench: three detector variants share one input stream; expected
// counts per pulse and LED high-run lengths are queued and checked by a monitor.
module tb_seq_detect_led;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w = 1'b0;
    logic       w_valid = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] led;
    logic [2:0] pulse;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [1:0] cnt_c;

    always #5 clk = ~clk;

    // A: defaults. B: no overlap, no retrigger. C: 2-bit counter, 1-cycle hold.
    seq_detect_led dut_a (
        .clk(clk), .rst(rst), .w(w), .w_valid(w_valid), .clear(clear),
        .led_out(led[0]), .match_pulse(pulse[0]), .match_count(cnt_a)
    );

    seq_detect_led #(.OVERLAP(1'b0), .RETRIGGER(1'b0)) dut_b (
        .clk(clk), .rst(rst), .w(w), .w_valid(w_valid), .clear(clear),
        .led_out(led[1]), .match_pulse(pulse[1]), .match_count(cnt_b)
    );

    seq_detect_led #(.CNT_W(2), .HOLD_CYCLES(1)) dut_c (
        .clk(clk), .rst(rst), .w(w), .w_valid(w_valid), .clear(clear),
        .led_out(led[2]), .match_pulse(pulse[2]), .match_count(cnt_c)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt_q[3][$];
    int exp_led_q[3][$];
    int run_len[3] = '{0, 0, 0};

    function automatic int cnt_of(int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one pop per match_pulse, one pop per completed LED high run.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pulse[i] === 1'b1) begin
                if (exp_cnt_q[i].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse dut%0d: count %0d, no match expected", i, cnt_of(i));
                end else begin
                    int e;
                    e = exp_cnt_q[i].pop_front();
                    check($sformatf("pulse_count dut%0d", i), cnt_of(i), e);
                    $display("t=%0t dut%0d match_pulse count=%0d expected=%0d", $time, i, cnt_of(i), e);
                end
            end
            if (led[i] === 1'b1) begin
                run_len[i]++;
            end else if (run_len[i] > 0) begin
                if (exp_led_q[i].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_led dut%0d: high %0d cycles, no run expected", i, run_len[i]);
                end else begin
                    int e;
                    e = exp_led_q[i].pop_front();
                    check($sformatf("led_len dut%0d", i), run_len[i], e);
                    $display("t=%0t dut%0d led run=%0d expected=%0d", $time, i, run_len[i], e);
                end
                run_len[i] = 0;
            end
        end
    end

    task automatic step(bit r, bit v, bit b, bit c);
        rst = r;
        w_valid = v;
        w = b;
        clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send(bit b);
        step(1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send(s[i] == 8'h31);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exp_cnt(int i, int v);
        exp_cnt_q[i].push_back(v);
    endtask

    task automatic exp_led(int i, int v);
        exp_led_q[i].push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_led dut%0d", i), int'(led[i]), 0);
            check($sformatf("reset_pulse dut%0d", i), int'(pulse[i]), 0);
            check($sformatf("reset_count dut%0d", i), cnt_of(i), 0);
        end

        // Basic 1101 detection.
        exp_cnt(0, 1); exp_led(0, 8);
        exp_cnt(1, 1); exp_led(1, 8);
        exp_cnt(2, 1); exp_led(2, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_str("1101");
        idle(12);

        // Overlapping pair: second match retriggers A at hold cycle 3.
        do_reset();
        exp_cnt(0, 1); exp_cnt(0, 2); exp_led(0, 11);
        exp_cnt(1, 1); exp_led(1, 8);
        exp_cnt(2, 1); exp_cnt(2, 2); exp_led(2, 1); exp_led(2, 1);
        send_str("1101101");
        idle(12);

        // Two disjoint patterns; B matches twice but ignores the second for hold.
        do_reset();
        exp_cnt(0, 1); exp_cnt(0, 2); exp_led(0, 12);
        exp_cnt(1, 1); exp_cnt(1, 2); exp_led(1, 8);
        exp_cnt(2, 1); exp_cnt(2, 2); exp_led(2, 1); exp_led(2, 1);
        send_str("11011101");
        idle(12);

        // Gapped valid with random w on invalid cycles.
        do_reset();
        exp_cnt(0, 1); exp_led(0, 8);
        exp_cnt(1, 1); exp_led(1, 8);
        exp_cnt(2, 1); exp_led(2, 1);
        send(1'b1); idle(2);
        send(1'b1); idle(3);
        send(1'b0); idle(1);
        send(1'b1);
        idle(12);

        // Clear on the completing bit, then clear mid-hold, then reset.
        do_reset();
        exp_cnt(0, 1); exp_led(0, 3);
        exp_cnt(1, 1); exp_led(1, 3);
        exp_cnt(2, 1); exp_led(2, 1);
        send_str("110");
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("clear_on_match pulse", int'(pulse[0]), 0);
        check("clear_on_match count", int'(cnt_a), 0);
        check("clear_on_match led", int'(led[0]), 0);
        send_str("1101");
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clear_mid_hold led dut0", int'(led[0]), 0);
        check("clear_mid_hold led dut1", int'(led[1]), 0);
        check("clear_mid_hold count dut0", int'(cnt_a), 1);
        check("clear_mid_hold count dut1", int'(cnt_b), 1);
        idle(2);
        do_reset();
        for (int i = 0; i < 3; i++) check($sformatf("rst_clears_count dut%0d", i), cnt_of(i), 0);

        // Five overlapping matches: C saturates, B sees three.
        exp_cnt(0, 1); exp_cnt(0, 2); exp_cnt(0, 3); exp_cnt(0, 4); exp_cnt(0, 5);
        exp_led(0, 20);
        exp_cnt(1, 1); exp_cnt(1, 2); exp_cnt(1, 3);
        exp_led(1, 8); exp_led(1, 8);
        exp_cnt(2, 1); exp_cnt(2, 2); exp_cnt(2, 3); exp_cnt(2, 3); exp_cnt(2, 3);
        for (int k = 0; k < 5; k++) exp_led(2, 1);
        send_str("1101101101101101");
        idle(12);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("pending_pulses dut%0d", i), exp_cnt_q[i].size(), 0);
            check($sformatf("pending_led_runs dut%0d", i), exp_led_q[i].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
